// File: rtl/nes_cpu_pkg.sv
// Shared NES CPU fetch types, opcode constants and the opcode length table.
// Defining FETCH_RESET_VECTOR_EN adds the VEC state used for reset-vector boot.
`ifndef BYTE
`define BYTE 8
`endif

package nes_cpu_pkg;

  localparam int MEM_ADDR_SIZE = 16;

  typedef logic [`BYTE-1:0] byte_t;

  localparam byte_t BRK     = 8'h00;
  localparam byte_t ORA_IMM = 8'h09;
  localparam byte_t JSR_ABS = 8'h20;
  localparam byte_t JMP_ABS = 8'h4C;
  localparam byte_t JMP_IND = 8'h6C;
  localparam byte_t LDA_IMM = 8'hA9;
  localparam byte_t LDA_ABS = 8'hAD;
  localparam byte_t BNE_REL = 8'hD0;
  localparam byte_t NOP     = 8'hEA;

`ifdef FETCH_RESET_VECTOR_EN
  typedef enum logic {ST_VEC, ST_FETCH} fetch_state_e;
  localparam fetch_state_e FETCH_RESET_STATE = ST_VEC;
`else
  typedef enum logic {ST_FETCH} fetch_state_e;
  localparam fetch_state_e FETCH_RESET_STATE = ST_FETCH;
`endif

  typedef logic [255:0][1:0] len_table_t;

  // Lengths follow the 6502 addressing mode implied by each opcode column;
  // undefined opcodes decode as single-byte so fetch always makes progress.
  function automatic len_table_t build_len_table();
    len_table_t t;
    byte_t      op;
    for (int i = 0; i < 256; i++) begin
      op   = 8'(i);
      t[i] = 2'd1;
      case (op[3:0])
        4'h0: begin
          if (op == JSR_ABS)                               t[i] = 2'd3;
          else if (op[4] || op inside {8'hA0, 8'hC0, 8'hE0}) t[i] = 2'd2;
        end
        4'h1, 4'h5, 4'h6: t[i] = 2'd2;
        4'h2: if (op == 8'hA2) t[i] = 2'd2;
        4'h4: if (op inside {8'h24, 8'h84, 8'h94, 8'hA4, 8'hB4, 8'hC4, 8'hE4}) t[i] = 2'd2;
        4'h9: begin
          if (op[4])            t[i] = 2'd3;
          else if (op != 8'h89) t[i] = 2'd2;
        end
        4'hC: if (op inside {8'h2C, 8'h4C, 8'h6C, 8'h8C, 8'hAC, 8'hBC, 8'hCC, 8'hEC}) t[i] = 2'd3;
        4'hD: t[i] = 2'd3;
        4'hE: if (op != 8'h9E) t[i] = 2'd3;
        default: t[i] = 2'd1;
      endcase
    end
    return t;
  endfunction

  localparam len_table_t OPCODE_LEN = build_len_table();

endpackage

// File: rtl/op_len_dec_t.sv
// Combinational opcode-to-length decoder backed by the package OPCODE_LEN table.
module op_len_dec_t
  import nes_cpu_pkg::*;
(
  input  byte_t      opcode,
  output logic [1:0] len
);

  assign len = OPCODE_LEN[opcode];

endmodule

// File: rtl/fetch_t.sv
// Instruction fetch stage: zero-wait memory, one-entry output slot, redirect.
// Defining FETCH_RESET_VECTOR_EN boots from the little-endian vector at VECTOR_ADDR.
module fetch_t
  import nes_cpu_pkg::*;
#(
  parameter logic [MEM_ADDR_SIZE-1:0] RESET_PC    = '0,
  parameter logic [MEM_ADDR_SIZE-1:0] VECTOR_ADDR = MEM_ADDR_SIZE'((2**MEM_ADDR_SIZE) - 4)
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  output logic [MEM_ADDR_SIZE-1:0] mem_addr_o,
  input  logic [23:0]              mem_data_i,
  output logic                     instr_valid_o,
  input  logic                     instr_ready_i,
  output logic [23:0]              instr_o,
  output logic [1:0]               instr_len_o,
  output logic [MEM_ADDR_SIZE-1:0] instr_pc_o,
  input  logic                     redirect_i,
  input  logic [MEM_ADDR_SIZE-1:0] redirect_pc_i
);

  fetch_state_e             state_q, state_d;
  logic [MEM_ADDR_SIZE-1:0] pc_q, pc_d;
  logic [1:0]               dec_len;
  logic                     load, flush;

  op_len_dec_t u_len_dec (
    .opcode (mem_data_i[7:0]),
    .len    (dec_len)
  );

  // Redirect outranks the handshake; the slot reloads whenever it is empty or drained.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_addr_o = pc_q;
    load       = 1'b0;
    flush      = 1'b0;
    case (state_q)
`ifdef FETCH_RESET_VECTOR_EN
      ST_VEC: begin
        mem_addr_o = VECTOR_ADDR;
        pc_d       = MEM_ADDR_SIZE'(mem_data_i[15:0]);
        state_d    = ST_FETCH;
      end
`endif
      ST_FETCH: begin
        if (redirect_i) begin
          flush = 1'b1;
          pc_d  = redirect_pc_i;
        end else if (!instr_valid_o || instr_ready_i) begin
          load = 1'b1;
          pc_d = pc_q + MEM_ADDR_SIZE'(dec_len);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= FETCH_RESET_STATE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      instr_valid_o <= 1'b0;
      instr_o       <= '0;
      instr_len_o   <= '0;
      instr_pc_o    <= '0;
    end else if (flush) begin
      instr_valid_o <= 1'b0;
    end else if (load) begin
      instr_valid_o <= 1'b1;
      instr_o       <= mem_data_i;
      instr_len_o   <= dec_len;
      instr_pc_o    <= pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_t.sv
// Randomized and directed checks of fetch_t against a slot-level reference model.
// Works with and without FETCH_RESET_VECTOR_EN.
module tb_fetch_t;
  import nes_cpu_pkg::*;

  localparam int AW = MEM_ADDR_SIZE;
  localparam logic [AW-1:0] VEC_ADDR = AW'((2**AW) - 4);
`ifdef FETCH_RESET_VECTOR_EN
  localparam logic [AW-1:0] PROG_BASE  = AW'(16'h0200);
  localparam logic [AW-1:0] START_ADDR = VEC_ADDR;
  localparam logic          BOOT_VEC   = 1'b1;
`else
  localparam logic [AW-1:0] PROG_BASE  = '0;
  localparam logic [AW-1:0] START_ADDR = '0;
  localparam logic          BOOT_VEC   = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [23:0]   mem_data;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [23:0]   instr;
  logic [1:0]    instr_len;
  logic [AW-1:0] instr_pc;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;

  logic [7:0]    mem [2**AW];
  logic [AW-1:0] a1, a2;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  logic          m_in_vec, m_valid;
  logic [AW-1:0] m_pc, m_ipc;
  logic [23:0]   m_instr;
  logic [1:0]    m_len;

  always #5 clk = ~clk;

  assign a1       = mem_addr + AW'(1);
  assign a2       = mem_addr + AW'(2);
  assign mem_data = {mem[a2], mem[a1], mem[mem_addr]};

  fetch_t dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .mem_addr_o    (mem_addr),
    .mem_data_i    (mem_data),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .instr_o       (instr),
    .instr_len_o   (instr_len),
    .instr_pc_o    (instr_pc),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc)
  );

  // Official 6502 opcodes by byte count; everything else is one byte.
  function automatic logic [1:0] ref_len(input logic [7:0] op);
    if (op inside {8'h20, 8'h19, 8'h39, 8'h59, 8'h79, 8'h99, 8'hB9, 8'hD9, 8'hF9,
                   8'h2C, 8'h4C, 8'h6C, 8'h8C, 8'hAC, 8'hBC, 8'hCC, 8'hEC,
                   8'h0D, 8'h1D, 8'h2D, 8'h3D, 8'h4D, 8'h5D, 8'h6D, 8'h7D,
                   8'h8D, 8'h9D, 8'hAD, 8'hBD, 8'hCD, 8'hDD, 8'hED, 8'hFD,
                   8'h0E, 8'h1E, 8'h2E, 8'h3E, 8'h4E, 8'h5E, 8'h6E, 8'h7E,
                   8'h8E, 8'hAE, 8'hBE, 8'hCE, 8'hDE, 8'hEE, 8'hFE})
      return 2'd3;
    if (op inside {8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0, 8'hF0,
                   8'hA0, 8'hC0, 8'hE0, 8'hA2,
                   8'h09, 8'h29, 8'h49, 8'h69, 8'hA9, 8'hC9, 8'hE9,
                   8'h01, 8'h11, 8'h21, 8'h31, 8'h41, 8'h51, 8'h61, 8'h71,
                   8'h81, 8'h91, 8'hA1, 8'hB1, 8'hC1, 8'hD1, 8'hE1, 8'hF1,
                   8'h05, 8'h15, 8'h25, 8'h35, 8'h45, 8'h55, 8'h65, 8'h75,
                   8'h85, 8'h95, 8'hA5, 8'hB5, 8'hC5, 8'hD5, 8'hE5, 8'hF5,
                   8'h06, 8'h16, 8'h26, 8'h36, 8'h46, 8'h56, 8'h66, 8'h76,
                   8'h86, 8'h96, 8'hA6, 8'hB6, 8'hC6, 8'hD6, 8'hE6, 8'hF6,
                   8'h24, 8'h84, 8'h94, 8'hA4, 8'hB4, 8'hC4, 8'hE4})
      return 2'd2;
    return 2'd1;
  endfunction

  function automatic logic [23:0] window(input logic [AW-1:0] a);
    logic [AW-1:0] b, c;
    b = a + AW'(1);
    c = a + AW'(2);
    return {mem[c], mem[b], mem[a]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_in_vec = BOOT_VEC;
    m_valid  = 1'b0;
    m_pc     = '0;
    m_ipc    = '0;
    m_instr  = '0;
    m_len    = '0;
  endtask

  task automatic model_step(input logic rdy, input logic rd, input logic [AW-1:0] rpc);
    logic [AW-1:0] hi;
    if (m_in_vec) begin
      hi       = VEC_ADDR + AW'(1);
      m_pc     = AW'({mem[hi], mem[VEC_ADDR]});
      m_in_vec = 1'b0;
    end else if (rd) begin
      m_pc    = rpc;
      m_valid = 1'b0;
    end else if (!m_valid || rdy) begin
      m_instr = window(m_pc);
      m_len   = ref_len(m_instr[7:0]);
      m_ipc   = m_pc;
      m_valid = 1'b1;
      m_pc    = m_pc + AW'(m_len);
    end
  endtask

  task automatic check_slot();
    check("valid", 32'(instr_valid), 32'(m_valid));
    check("mem_addr", 32'(mem_addr), 32'(m_in_vec ? VEC_ADDR : m_pc));
    if (m_valid) begin
      check("instr", 32'(instr), 32'(m_instr));
      check("len", 32'(instr_len), 32'(m_len));
      check("instr_pc", 32'(instr_pc), 32'(m_ipc));
      check("len_nonzero", 32'(instr_len != 2'd0), 32'd1);
    end
  endtask

  task automatic cycle(input logic rdy, input logic rd, input logic [AW-1:0] rpc);
    instr_ready = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    model_step(rdy, rd, rpc);
    @(posedge clk);
    #1;
    check_slot();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_instr"}, 32'(instr), 32'd0);
    check({tag, "_len"}, 32'(instr_len), 32'd0);
    check({tag, "_pc"}, 32'(instr_pc), 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'(START_ADDR));
  endtask

  initial begin
    logic [7:0]    prog [6];
    logic [AW-1:0] addr;
    logic          rdy, rd;

    prog = '{8'h09, 8'h41, 8'hAD, 8'h34, 8'h12, 8'hEA};
    for (int i = 0; i < 2**AW; i++) mem[i] = 8'($urandom);
    for (int k = 0; k < 6; k++) begin
      addr      = PROG_BASE + AW'(k);
      mem[addr] = prog[k];
    end
    addr      = VEC_ADDR + AW'(1);
    mem[VEC_ADDR] = 8'h00;
    mem[addr]     = 8'h02;
    addr      = AW'((2**AW) - 2);
    mem[addr] = LDA_ABS;

    model_reset();
    #12;
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rstn = 1'b1;
    check("boot_addr", 32'(mem_addr), 32'(START_ADDR));

`ifdef FETCH_RESET_VECTOR_EN
    cycle(1'b1, 1'b1, AW'(16'h0077));
    check("vec_pc", 32'(mem_addr), 32'(PROG_BASE));
`endif

    cycle(1'b1, 1'b0, '0);
    check("i0_pc", 32'(instr_pc), 32'(PROG_BASE));
    check("i0_len", 32'(instr_len), 32'd2);
    check("i0_instr", 32'(instr), 32'h00AD4109);

    cycle(1'b1, 1'b0, '0);
    check("i1_pc", 32'(instr_pc), 32'(PROG_BASE + AW'(2)));
    check("i1_len", 32'(instr_len), 32'd3);
    check("i1_instr", 32'(instr), 32'h001234AD);

    repeat (3) begin
      cycle(1'b0, 1'b0, '0);
      check("stall_pc", 32'(instr_pc), 32'(PROG_BASE + AW'(2)));
      check("stall_instr", 32'(instr), 32'h001234AD);
      check("stall_addr", 32'(mem_addr), 32'(PROG_BASE + AW'(5)));
    end

    cycle(1'b1, 1'b0, '0);
    check("i2_pc", 32'(instr_pc), 32'(PROG_BASE + AW'(5)));
    check("i2_len", 32'(instr_len), 32'd1);
    check("i2_op", 32'(instr[7:0]), 32'hEA);

    cycle(1'b1, 1'b1, AW'(16'h0010));
    check("redir_valid", 32'(instr_valid), 32'd0);
    cycle(1'($urandom), 1'b0, '0);
    check("redir_pc", 32'(instr_pc), 32'h10);

    cycle(1'b1, 1'b1, AW'((2**AW) - 2));
    cycle(1'b1, 1'b0, '0);
    check("wrap_len", 32'(instr_len), 32'd3);
    check("wrap_next", 32'(mem_addr), 32'd1);

    repeat (400) begin
      rdy = ($urandom_range(0, 9) < 7);
      rd  = ($urandom_range(0, 19) == 0);
      cycle(rdy, rd, AW'($urandom));
    end

    cycle(1'b1, 1'b0, '0);
    check("pre_rst_valid", 32'(instr_valid), 32'd1);
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("midrst");
    @(posedge clk);
    #1 rstn = 1'b1;
`ifdef FETCH_RESET_VECTOR_EN
    cycle(1'b1, 1'b0, '0);
`endif
    cycle(1'b1, 1'b0, '0);
    check("restart_pc", 32'(instr_pc), 32'(PROG_BASE));
    repeat (5) cycle(1'b1, 1'b0, '0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
